spi_wrapper: RTL and testbench
==============================

# spi_wrapper

SPI slave with an attached single-port RAM. It lets an external SPI master write a RAM address, write data, set a read address, and read data back over a single MOSI/MISO pair. Internally it is an SPI slave FSM, for serial-to-parallel and parallel-to-serial conversion, feeding a command-decoded RAM through a 10-bit rx bus and an 8-bit tx bus. Verification probes internal nodes by hierarchical name: `rx_data_din`, `rx_valid`, `tx_data_dout`, `tx_valid`, and `RAM_inst` with its `RAM`, `Wr_Addr` and `Rd_Addr`.

## Interface
- MEM_DEPTH, default 256: RAM word count.
- ADDR_SIZE, default 8: address width. Addresses are taken from `rx_data[7:0]`.
- clk  input  1  single clock; all logic is posedge.
- rst  input  1  asynchronous, active-high reset.
- MOSI  input  1  serial data from the master, MSB first.
- SS_n  input  1  active-low slave select; a frame is the interval while it is low.
- MISO  output  1  serial read data to the master, MSB first.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE goes to CHK_CMD on a clock edge with SS_n=0.
- CHK_CMD samples MOSI:
  - MOSI=0 goes to WRITE.
  - MOSI=1 goes to READ_DATA if `rd_addr_received` is set, otherwise to READ_ADD.
- In any state, SS_n=1 goes to IDLE on the next edge. This aborts the frame, clears the bit counter and leaves rx_valid low.
- WRITE, READ_ADD and READ_DATA each shift 10 MOSI bits MSB first into `rx_data[9:0]`, one bit per edge.
- On the edge that samples the 10th bit:
  - `rx_data_din` is updated.
  - `rx_valid` pulses high for exactly one cycle.
- RAM decode of `rx_data[9:8]` happens on the edge where rx_valid=1:
  - 00: `Wr_Addr` <= `din[7:0]`.
  - 01: `RAM[Wr_Addr]` <= `din[7:0]`.
  - 10: `Rd_Addr` <= `din[7:0]`.
  - 11: `tx_data_dout` <= `RAM[Rd_Addr]`, and `tx_valid` <= 1 for one cycle.
- `rd_addr_received` is set when a READ_ADD frame completes and cleared when a READ_DATA frame completes.
- READ_DATA, transmit phase:
  - After the 10-bit receive, the FSM waits for tx_valid and latches `tx_data_dout`.
  - On each following edge it drives MISO with bits 7, 6, …, 0.
  - It then holds MISO=0 and stays in READ_DATA until SS_n=1.
- Reset values:
  - FSM in IDLE; counters 0.
  - MISO=0; rx_data=0; rx_valid=0.
  - Wr_Addr=0; Rd_Addr=0; dout=0; tx_valid=0.
  - `rd_addr_received`=0.
- RAM array contents are not reset; they may be preloaded via `$readmemh`.
- MOSI bits in READ_DATA's 8 data positions are don't-care.

## Timing
Edge 1 is the first posedge with SS_n=0.
- Edge 1: IDLE goes to CHK_CMD.
- Edge 2: MOSI is sampled as the command and the FSM goes to WRITE, READ_ADD or READ_DATA.
- Edges 3–12: `din[9]` down to `din[0]`. At edge 12, rx_valid=1 and rx_data is valid.
- Edge 13: the RAM acts.
  - Address and data registers are updated, readable after edge 13.
  - For an 11 frame, tx_valid=1 and tx_data_dout is valid.
- Edges 14–21: MISO carries `dout[7]` through `dout[0]`, each bit valid after its edge and sampled by the master on the following negedge.
- The master may raise SS_n for edge 13 on write and read-address frames; the RAM action at edge 13 must still occur.
- Minimum SS_n-low time for a read-data frame is 21 edges.
- Frame length below 12 edges: no RAM effect.

## Test plan
- Reset: hold rst=1 for 5 cycles with random MOSI/SS_n -> MISO=0, state IDLE, Wr_Addr=0, Rd_Addr=0, tx_valid=0.
- Write address: SS_n low, MOSI 0, then bits 00 + 8'hA5 -> Wr_Addr=0xA5 one edge after SS_n rises.
- Write data: SS_n low, MOSI 0, then bits 01 + 8'h3C -> RAM[0xA5]=0x3C.
- Read address: SS_n low, MOSI 1, then bits 10 + 8'h12 -> Rd_Addr=0x12 and `rd_addr_received`=1.
- Read data: preload RAM[0x12]=0x9E; SS_n low, MOSI 1, then bits 11 + 8 dummy bits -> tx_valid pulses at edge 13; MISO reads 1,0,0,1,1,1,1,0 on edges 14–21; `rd_addr_received` is cleared.
- Abort: raise SS_n after 6 data bits of a 00 frame -> FSM goes to IDLE, rx_valid stays 0, Wr_Addr unchanged. A subsequent full frame works normally.

Source files
------------

// File: rtl/spi_wrapper.sv
// SPI slave front end plus a command-decoded single-port RAM.
// A frame is one command bit followed by a 10-bit word, MSB first. The
// top two bits of the word select the RAM operation: 00 = set write
// address, 01 = write data, 10 = set read address, 11 = read data.
// A read-data frame then returns the addressed byte on MISO, MSB first.
//
// FSM states:
//   state     | meaning
//   IDLE      | SS_n high or frame not yet started
//   CHK_CMD   | sampling the command bit on MOSI
//   WRITE     | receiving a write-address or write-data word
//   READ_ADD  | receiving a read-address word
//   READ_DATA | receiving a read-data word, then shifting the byte out

module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  logic [7:0]           RAM [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] Wr_Addr;
  logic [ADDR_SIZE-1:0] Rd_Addr;

  // Address registers, read port and the one-cycle tx_valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Wr_Addr  <= '0;
      Rd_Addr  <= '0;
      dout     <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (din[9:8])
          2'b00: Wr_Addr <= din[ADDR_SIZE-1:0];
          2'b10: Rd_Addr <= din[ADDR_SIZE-1:0];
          2'b11: begin
            dout     <= RAM[Rd_Addr];
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Array write; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rx_valid && (din[9:8] == 2'b01)) begin
      RAM[Wr_Addr] <= din[7:0];
    end
  end

endmodule

module spi_wrapper #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t state;
  state_t next_state;

  logic [9:0] rx_data_din;
  logic       rx_valid;
  logic [7:0] tx_data_dout;
  logic       tx_valid;

  logic [8:0] rx_shift;
  logic [3:0] bit_cnt;
  logic       rx_done;
  logic       rd_addr_received;

  logic [7:0] tx_shift;
  logic [2:0] tx_cnt;
  logic       tx_busy;
  logic       tx_done;

  logic       in_data_state;
  logic       in_read_data;
  logic       last_bit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and shared frame qualifiers.
  always_comb begin
    next_state    = state;
    in_data_state = 1'b0;
    in_read_data  = 1'b0;
    last_bit      = 1'b0;
    if (SS_n) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI) begin
            next_state = WRITE;
          end else if (rd_addr_received) begin
            next_state = READ_DATA;
          end else begin
            next_state = READ_ADD;
          end
        end
        default: next_state = state;
      endcase
      in_data_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
      in_read_data  = (state == READ_DATA);
      last_bit      = in_data_state && !rx_done && (bit_cnt == 4'd9);
    end
  end

  // Serial-to-parallel receive; the word is published with a one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift    <= 9'h000;
      bit_cnt     <= 4'd0;
      rx_done     <= 1'b0;
      rx_data_din <= 10'h000;
      rx_valid    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!in_data_state) begin
        bit_cnt <= 4'd0;
        rx_done <= 1'b0;
      end else if (!rx_done) begin
        rx_shift <= {rx_shift[7:0], MOSI};
        if (bit_cnt == 4'd9) begin
          rx_data_din <= {rx_shift, MOSI};
          rx_valid    <= 1'b1;
          rx_done     <= 1'b1;
          bit_cnt     <= 4'd0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  // Tracks whether a read address is pending, which steers the next read command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_received <= 1'b0;
    end else if (last_bit) begin
      if (state == READ_ADD) begin
        rd_addr_received <= 1'b1;
      end else if (state == READ_DATA) begin
        rd_addr_received <= 1'b0;
      end
    end
  end

  // Parallel-to-serial transmit of the read byte; tx_cnt counts remaining bits down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MISO     <= 1'b0;
      tx_shift <= 8'h00;
      tx_cnt   <= 3'd0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else if (!in_read_data) begin
      MISO    <= 1'b0;
      tx_cnt  <= 3'd0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == 3'd0) begin
        MISO    <= 1'b0;
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end else begin
        MISO     <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
        tx_cnt   <= tx_cnt - 3'd1;
      end
    end else if (rx_done && !tx_done && tx_valid) begin
      MISO     <= tx_data_dout[7];
      tx_shift <= {tx_data_dout[6:0], 1'b0};
      tx_cnt   <= 3'd7;
      tx_busy  <= 1'b1;
    end else begin
      MISO <= 1'b0;
    end
  end

  spi_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) RAM_inst (
    .clk      (clk),
    .rst      (rst),
    .din      (rx_data_din),
    .rx_valid (rx_valid),
    .dout     (tx_data_dout),
    .tx_valid (tx_valid)
  );

endmodule

// File: tb/tb_spi_wrapper.sv
// Bench for spi_wrapper: directed frames from the bring-up list followed by
// randomized frames, all compared against a simple array model of the RAM
// and its address registers.

module tb_spi_wrapper;

  logic clk;
  logic rst;
  logic MOSI;
  logic SS_n;
  logic MISO;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  bit         m_rdrx;
  logic [7:0] known_q [$];

  spi_wrapper dut (
    .clk  (clk),
    .rst  (rst),
    .MOSI (MOSI),
    .SS_n (SS_n),
    .MISO (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowers SS_n before edge 1 and presents the command bit for edge 2.
  task automatic start_frame(input logic cmd);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    @(negedge clk);
    MOSI = cmd;
  endtask

  task automatic shift_bits(input logic [9:0] b, input int n);
    for (int i = 9; i > 9 - n; i--) begin
      @(negedge clk);
      MOSI = b[i];
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    @(negedge clk);
  endtask

  // Full 10-bit word plus check of the receive strobe after edge 12.
  task automatic send_word(input logic cmd, input logic [9:0] b);
    start_frame(cmd);
    shift_bits(b, 10);
    @(negedge clk);
    check("rx_valid_edge12", 32'(dut.rx_valid), 32'h1);
    check("rx_data_din", 32'(dut.rx_data_din), 32'(b));
  endtask

  task automatic write_frame(input logic [1:0] op, input logic [7:0] val);
    bit early;
    send_word(1'b0, {op, val});
    early = 1'($urandom);
    if (early) SS_n = 1'b1;
    else MOSI = 1'($urandom);
    @(negedge clk);
    check("rx_valid_edge13", 32'(dut.rx_valid), 32'h0);
    if (op == 2'b00) begin
      m_wr = val;
    end else begin
      m_mem[m_wr] = val;
      if (!m_known[m_wr]) begin
        m_known[m_wr] = 1'b1;
        known_q.push_back(m_wr);
      end
      check("ram_word", 32'(dut.RAM_inst.RAM[m_wr]), 32'(val));
    end
    check("wr_addr", 32'(dut.RAM_inst.Wr_Addr), 32'(m_wr));
    if (!early) begin
      repeat ($urandom_range(0, 3)) begin
        MOSI = 1'($urandom);
        @(negedge clk);
        check("rx_valid_hold", 32'(dut.rx_valid), 32'h0);
      end
    end
    end_frame();
  endtask

  task automatic read_addr_frame(input logic [7:0] a);
    send_word(1'b1, {2'b10, a});
    if (1'($urandom)) SS_n = 1'b1;
    @(negedge clk);
    m_rd   = a;
    m_rdrx = 1'b1;
    check("rd_addr", 32'(dut.RAM_inst.Rd_Addr), 32'(m_rd));
    check("rd_addr_received_set", 32'(dut.rd_addr_received), 32'h1);
    end_frame();
  endtask

  task automatic read_data_frame();
    logic [7:0] exp;
    exp = m_mem[m_rd];
    send_word(1'b1, {2'b11, 8'($urandom)});
    MOSI = 1'($urandom);
    @(negedge clk);
    m_rdrx = 1'b0;
    check("tx_valid_edge13", 32'(dut.tx_valid), 32'h1);
    check("tx_data_dout", 32'(dut.tx_data_dout), 32'(exp));
    check("rd_addr_received_clr", 32'(dut.rd_addr_received), 32'h0);
    for (int i = 7; i >= 0; i--) begin
      MOSI = 1'($urandom);
      @(negedge clk);
      check("miso_bit", 32'(MISO), 32'(exp[i]));
      if (i == 7) check("tx_valid_edge14", 32'(dut.tx_valid), 32'h0);
    end
    repeat ($urandom_range(1, 3)) begin
      MOSI = 1'($urandom);
      @(negedge clk);
      check("miso_tail", 32'(MISO), 32'h0);
    end
    end_frame();
  endtask

  task automatic abort_frame(input logic cmd, input logic [9:0] b, input int n);
    start_frame(cmd);
    shift_bits(b, n);
    @(negedge clk);
    SS_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_rx_valid", 32'(dut.rx_valid), 32'h0);
    end
    check("abort_wr_addr", 32'(dut.RAM_inst.Wr_Addr), 32'(m_wr));
    check("abort_rd_addr", 32'(dut.RAM_inst.Rd_Addr), 32'(m_rd));
    check("abort_rd_rx", 32'(dut.rd_addr_received), 32'(m_rdrx));
    check("abort_miso", 32'(MISO), 32'h0);
  endtask

  initial begin
    rst  = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    m_wr = 8'h00;
    m_rd = 8'h00;
    m_rdrx = 1'b0;
    foreach (m_known[i]) m_known[i] = 1'b0;

    // reset with random inputs
    repeat (5) begin
      @(negedge clk);
      MOSI = 1'($urandom);
      SS_n = 1'($urandom);
    end
    @(negedge clk);
    check("rst_miso", 32'(MISO), 32'h0);
    check("rst_wr_addr", 32'(dut.RAM_inst.Wr_Addr), 32'h0);
    check("rst_rd_addr", 32'(dut.RAM_inst.Rd_Addr), 32'h0);
    check("rst_tx_valid", 32'(dut.tx_valid), 32'h0);
    check("rst_rx_valid", 32'(dut.rx_valid), 32'h0);
    check("rst_rd_rx", 32'(dut.rd_addr_received), 32'h0);
    SS_n = 1'b1;
    rst  = 1'b0;
    @(negedge clk);

    // directed frames
    write_frame(2'b00, 8'h12);
    write_frame(2'b01, 8'h9E);
    write_frame(2'b00, 8'hA5);
    write_frame(2'b01, 8'h3C);
    read_addr_frame(8'h12);
    read_data_frame();
    read_addr_frame(8'hA5);
    read_data_frame();
    abort_frame(1'b0, {2'b00, 8'h5A}, 6);
    write_frame(2'b00, 8'h77);
    abort_frame(1'b0, {2'b01, 8'hFF}, 9);
    check("abort_ram_kept", 32'(dut.RAM_inst.RAM[8'hA5]), 32'h3C);

    // randomized frames
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: write_frame(2'b00, 8'($urandom));
        1: write_frame(2'b01, 8'($urandom));
        2: abort_frame(1'($urandom), 10'($urandom), int'($urandom_range(0, 9)));
        default: begin
          read_addr_frame(known_q[$urandom_range(0, known_q.size() - 1)]);
          read_data_frame();
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
